// File: rtl/sq_pkg.sv
// Shared constants, state encoding and sizing helper for the Sq coefficient unpacker.
package sq_pkg;
  localparam int COEF_W = 13;
  localparam int Q_LOG  = 13;
  localparam int N      = 701;
  localparam int N_PACK = N - 1;

  typedef logic [COEF_W-1:0] sq_coef_t;
  typedef enum logic {S_UNPACK = 1'b0, S_FINAL = 1'b1} sq_state_e;

  function automatic int sq_bytes(input int n, input int w);
    return (n * w + 7) / 8;
  endfunction
endpackage

// File: rtl/sq_unpack_if.sv
// Byte-in / coefficient-out handshake bundle for the Sq unpacker.
interface sq_unpack_if #(
  parameter int COEF_W = 13,
  parameter int IDX_W  = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] out_coef;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              frame_done;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_coef, out_idx, out_valid, out_last, frame_done);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_coef, out_idx, out_valid, out_last, frame_done);
endinterface

// File: rtl/sq_bit_window.sv
// LSB-first bit window: bytes are ORed in above the valid bits, coefficients leave from the bottom.
module sq_bit_window #(
  parameter  int COEF_W = 13,
  localparam int BUF_W  = COEF_W + 7,
  localparam int CNT_W  = $clog2(BUF_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [7:0]        din,
  input  logic              pop,
  output logic [COEF_W-1:0] word,
  output logic              full,
  output logic              room
);
  localparam logic [CNT_W-1:0] W_N = CNT_W'(COEF_W);

  logic [BUF_W-1:0] win;
  logic [CNT_W-1:0] bit_cnt;

  // push only happens below COEF_W bits, so the shifted byte always fits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win     <= '0;
      bit_cnt <= '0;
    end else if (flush) begin
      win     <= '0;
      bit_cnt <= '0;
    end else if (push) begin
      win     <= win | (BUF_W'(din) << bit_cnt);
      bit_cnt <= bit_cnt + CNT_W'(8);
    end else if (pop) begin
      win     <= win >> COEF_W;
      bit_cnt <= bit_cnt - W_N;
    end
  end

  assign word = win[COEF_W-1:0];
  assign full = (bit_cnt >= W_N);
  assign room = !full;
endmodule

// File: rtl/sq_unpack.sv
// Sq polynomial byte-stream decoder: N_PACK packed coefficients, then an optional
// sum-zero coefficient equal to the negated running sum mod 2^COEF_W.
module sq_unpack #(
  parameter  int COEF_W   = 13,
  parameter  int N_PACK   = 700,
  parameter  int SUM_ZERO = 1,
  localparam int N_BYTES  = sq_pkg::sq_bytes(N_PACK, COEF_W),
  localparam int IDX_W    = $clog2(N_PACK + 1),
  localparam int BC_W     = $clog2(N_BYTES + 1)
) (
  input logic        clk,
  input logic        rst,
  input logic        clear,
  sq_unpack_if.slave bus
);
  import sq_pkg::*;

  sq_state_e         state, state_nx;
  logic              run, done_q;
  logic [IDX_W-1:0]  coef_cnt, idx;
  logic [BC_W-1:0]   byte_cnt;
  logic [COEF_W-1:0] sum, win_word, coef;
  logic              win_full, win_room, in_rdy, vld, last;
  logic              in_hs, out_hs, pop, last_pk, frame_end, flush;

  assign last_pk   = (coef_cnt == IDX_W'(N_PACK - 1));
  assign in_hs     = bus.in_valid && in_rdy;
  assign out_hs    = vld && bus.out_ready && !clear;
  assign pop       = out_hs && (state == S_UNPACK);
  assign frame_end = out_hs && last;
  // trailing pad bits are dropped when the last packed coefficient leaves
  assign flush     = clear || frame_end || (pop && last_pk);

  sq_bit_window #(.COEF_W(COEF_W)) u_win (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (in_hs),
    .din  (bus.in_data),
    .pop  (pop),
    .word (win_word),
    .full (win_full),
    .room (win_room)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_UNPACK;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) state_nx = S_UNPACK;
    else if (out_hs) begin
      case (state)
        S_UNPACK: if (last_pk && SUM_ZERO != 0) state_nx = S_FINAL;
        S_FINAL:  state_nx = S_UNPACK;
        default:  state_nx = S_UNPACK;
      endcase
    end
  end

  always_comb begin
    in_rdy = 1'b0;
    vld    = 1'b0;
    coef   = win_word;
    idx    = coef_cnt;
    last   = 1'b0;
    case (state)
      S_UNPACK: begin
        in_rdy = run && win_room && (byte_cnt < BC_W'(N_BYTES)) && !clear;
        vld    = win_full;
        last   = win_full && last_pk && (SUM_ZERO == 0);
      end
      S_FINAL: begin
        vld  = 1'b1;
        coef = '0 - sum;
        idx  = IDX_W'(N_PACK);
        last = 1'b1;
      end
      default: ;
    endcase
  end

  // run holds in_ready low until the first edge out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      done_q   <= 1'b0;
      byte_cnt <= '0;
      coef_cnt <= '0;
      sum      <= '0;
    end else begin
      run    <= 1'b1;
      done_q <= frame_end;
      if (clear || frame_end) begin
        byte_cnt <= '0;
        coef_cnt <= '0;
        sum      <= '0;
      end else begin
        if (in_hs) byte_cnt <= byte_cnt + 1'b1;
        if (pop) begin
          coef_cnt <= coef_cnt + 1'b1;
          sum      <= sum + win_word;
        end
      end
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = vld;
  assign bus.out_coef   = coef;
  assign bus.out_idx    = idx;
  assign bus.out_last   = last;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_sq_unpack.sv
// Directed bench for sq_unpack: default 700+1 frame plus a 3-coefficient no-sum-zero instance.
module tb_sq_unpack;
  localparam int NB = 1138;

  logic clk = 1'b0;
  logic rst, clear0, clear1;
  always #5 clk = ~clk;

  sq_unpack_if #(.COEF_W(13), .IDX_W(10)) b0();
  sq_unpack_if #(.COEF_W(13), .IDX_W(2))  b1();

  sq_unpack d0 (.clk(clk), .rst(rst), .clear(clear0), .bus(b0));
  sq_unpack #(.N_PACK(3), .SUM_ZERO(0)) d1 (.clk(clk), .rst(rst), .clear(clear1), .bus(b1));

  int vecs = 0, errs = 0;
  logic [7:0]  stream [NB];
  logic [12:0] got    [701];
  logic [12:0] ref_c  [701];
  int got_n, bytes_in, stall_bad, rdy_bad, idx_bad, last_bad, done_lag;
  bit done_seen;

  task automatic fill(input int pat);
    for (int i = 0; i < NB; i++) begin
      case (pat)
        1:       stream[i] = (i == 0) ? 8'h01 : (i == 1) ? 8'h40 : 8'h00;
        2:       stream[i] = (i == 0) ? 8'hFF : (i == 1) ? 8'h1F : 8'h00;
        default: stream[i] = 8'(i * 37 + 5);
      endcase
    end
  endtask

  // Drives one frame into d0 and records what comes out; stop_at ends early after that many coefs.
  task automatic run_frame(input int rdy_div, input bit gaps, input int stop_at);
    int cyc = 0, last_hs = 0;
    bit stalled = 0;
    logic [12:0] pc = '0;
    logic [9:0]  pi = '0;
    logic        pl = 1'b0;
    got_n = 0; bytes_in = 0; stall_bad = 0; rdy_bad = 0; idx_bad = 0; last_bad = 0;
    done_lag = -1; done_seen = 0;
    while (!done_seen && got_n != stop_at && cyc < 10000) begin
      b0.in_valid  = (bytes_in < NB) && (!gaps || $urandom_range(0, 2) != 0);
      b0.in_data   = (bytes_in < NB) ? stream[bytes_in] : 8'h00;
      b0.out_ready = (rdy_div <= 1) || (cyc % rdy_div == 0);
      #1;
      if (b0.frame_done) begin done_seen = 1; done_lag = cyc - last_hs; end
      if (stalled && (!b0.out_valid || b0.out_coef !== pc || b0.out_idx !== pi || b0.out_last !== pl))
        stall_bad++;
      if (b0.in_ready && b0.out_valid) rdy_bad++;
      if (b0.out_valid && b0.out_ready && got_n < 701) begin
        got[got_n] = b0.out_coef;
        if (b0.out_idx !== 10'(got_n)) idx_bad++;
        if (b0.out_last !== (got_n == 700)) last_bad++;
        got_n++;
        last_hs = cyc;
      end
      if (b0.in_valid && b0.in_ready) bytes_in++;
      stalled = b0.out_valid && !b0.out_ready;
      pc = b0.out_coef; pi = b0.out_idx; pl = b0.out_last;
      @(posedge clk); #1;
      cyc++;
    end
    b0.in_valid = 1'b0; b0.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    b0.in_valid = 0; b0.in_data = 0; b0.out_ready = 0;
    b1.in_valid = 0; b1.in_data = 0; b1.out_ready = 0;
    clear0 = 0; clear1 = 0;
    rst = 1'b1; #2; rst = 1'b0; #2;
    vecs++; if ({b0.in_ready, b0.out_valid, b0.out_last, b0.frame_done} !== 4'b0)
      begin errs++; $display("FAIL reset_flags0: got %b want 0000", {b0.in_ready, b0.out_valid, b0.out_last, b0.frame_done}); end
    vecs++; if ({b0.out_coef, b0.out_idx} !== 23'h0)
      begin errs++; $display("FAIL reset_data0: got coef %h idx %0d want 0 0", b0.out_coef, b0.out_idx); end
    vecs++; if ({b1.in_ready, b1.out_valid, b1.out_last, b1.frame_done, b1.out_coef, b1.out_idx} !== 19'h0)
      begin errs++; $display("FAIL reset_d1: got nonzero outputs on small instance"); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    vecs++; if (b0.in_ready !== 1'b1) begin errs++; $display("FAIL ready_after_reset: got %b want 1", b0.in_ready); end
  endtask

  task automatic test_basic;
    int nz = 0;
    fill(1);
    run_frame(1, 0, -1);
    for (int i = 2; i < 700; i++) if (got[i] !== 13'h0) nz++;
    vecs++; if (got[0] !== 13'h0001) begin errs++; $display("FAIL basic_c0: got %h want 0001", got[0]); end
    vecs++; if (got[1] !== 13'h0002) begin errs++; $display("FAIL basic_c1: got %h want 0002", got[1]); end
    vecs++; if (nz !== 0) begin errs++; $display("FAIL basic_zeros: got %0d nonzero want 0", nz); end
    vecs++; if (got[700] !== 13'h1FFD) begin errs++; $display("FAIL basic_final: got %h want 1ffd", got[700]); end
    vecs++; if (got_n !== 701) begin errs++; $display("FAIL basic_count: got %0d want 701", got_n); end
    vecs++; if (bytes_in !== NB) begin errs++; $display("FAIL basic_bytes: got %0d want %0d", bytes_in, NB); end
    vecs++; if (done_lag !== 1) begin errs++; $display("FAIL basic_done_lag: got %0d want 1", done_lag); end
    vecs++; if (idx_bad !== 0 || last_bad !== 0)
      begin errs++; $display("FAIL basic_idx_last: got %0d/%0d bad want 0/0", idx_bad, last_bad); end
  endtask

  task automatic test_allones;
    fill(2);
    run_frame(1, 0, -1);
    vecs++; if (got[0] !== 13'h1FFF) begin errs++; $display("FAIL ones_c0: got %h want 1fff", got[0]); end
    vecs++; if (got[700] !== 13'h0001) begin errs++; $display("FAIL ones_final: got %h want 0001", got[700]); end
    vecs++; if (got_n !== 701 || !done_seen)
      begin errs++; $display("FAIL ones_frame: got %0d coefs done %0d want 701 1", got_n, done_seen); end
  endtask

  task automatic test_backpressure;
    int diffs = 0;
    fill(3);
    run_frame(1, 0, -1);
    for (int i = 0; i < 701; i++) ref_c[i] = got[i];
    vecs++; if (got[0] !== 13'h0A05) begin errs++; $display("FAIL bp_c0: got %h want 0a05", got[0]); end
    vecs++; if (got[1] !== 13'h0279) begin errs++; $display("FAIL bp_c1: got %h want 0279", got[1]); end
    run_frame(3, 1, -1);
    for (int i = 0; i < 701; i++) if (got[i] !== ref_c[i]) diffs++;
    vecs++; if (got_n !== 701 || diffs !== 0)
      begin errs++; $display("FAIL bp_sequence: got %0d coefs %0d diffs want 701 0", got_n, diffs); end
    vecs++; if (stall_bad !== 0) begin errs++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
    vecs++; if (rdy_bad !== 0) begin errs++; $display("FAIL bp_ready_excl: got %0d overlaps want 0", rdy_bad); end
    vecs++; if (bytes_in !== NB) begin errs++; $display("FAIL bp_bytes: got %0d want %0d", bytes_in, NB); end
    vecs++; if (idx_bad !== 0 || last_bad !== 0 || !done_seen)
      begin errs++; $display("FAIL bp_idx_last: got %0d/%0d bad done %0d want 0/0 1", idx_bad, last_bad, done_seen); end
  endtask

  task automatic test_small;
    for (int f = 0; f < 2; f++) begin
      int nb = 0, nc = 0, rdy_after = 0;
      bit done = 0;
      logic [12:0] c [3];
      logic [2:0]  lst = '0;
      logic [12:0] want [3];
      c[0] = '0; c[1] = '0; c[2] = '0;
      want[0] = (f == 0) ? 13'h1FFF : 13'h0001;
      want[1] = (f == 0) ? 13'h1FFF : 13'h0000;
      want[2] = (f == 0) ? 13'h1FFF : 13'h0000;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
        b1.in_valid  = (nb < 5);
        b1.in_data   = (f == 0) ? 8'hFF : (nb == 0) ? 8'h01 : 8'h00;
        b1.out_ready = 1'b1;
        #1;
        if (b1.frame_done) done = 1;
        else begin
          if (nb == 5 && b1.in_ready) rdy_after++;
          if (b1.out_valid) begin
            if (nc < 3) begin c[nc] = b1.out_coef; lst[nc] = b1.out_last; end
            nc++;
          end
          if (b1.in_valid && b1.in_ready) nb++;
        end
        @(posedge clk); #1;
      end
      b1.in_valid = 1'b0; b1.out_ready = 1'b0;
      vecs++; if (c[0] !== want[0] || c[1] !== want[1] || c[2] !== want[2])
        begin errs++; $display("FAIL small%0d_coefs: got %h %h %h want %h %h %h", f, c[0], c[1], c[2], want[0], want[1], want[2]); end
      vecs++; if (lst !== 3'b100 || nc !== 3)
        begin errs++; $display("FAIL small%0d_last: got last %b n %0d want 100 3", f, lst, nc); end
      vecs++; if (nb !== 5 || rdy_after !== 0 || !done)
        begin errs++; $display("FAIL small%0d_bytes: got %0d bytes %0d late ready done %0d want 5 0 1", f, nb, rdy_after, done); end
    end
  endtask

  task automatic test_clear;
    fill(1);
    run_frame(1, 0, 11);
    clear0 = 1'b1; b0.in_valid = 1'b1; b0.in_data = 8'hAA; b0.out_ready = 1'b1;
    #1;
    vecs++; if (b0.in_ready !== 1'b0) begin errs++; $display("FAIL clear_ready: got %b want 0", b0.in_ready); end
    @(posedge clk); #1;
    clear0 = 1'b0; b0.in_valid = 1'b0; b0.out_ready = 1'b0;
    #1;
    vecs++; if (b0.frame_done !== 1'b0 || b0.out_valid !== 1'b0 || b0.out_idx !== 10'd0)
      begin errs++; $display("FAIL clear_state: got done %b vld %b idx %0d want 0 0 0", b0.frame_done, b0.out_valid, b0.out_idx); end
    @(posedge clk); #1;
    vecs++; if (b0.frame_done !== 1'b0) begin errs++; $display("FAIL clear_no_done: got %b want 0", b0.frame_done); end
    fill(2);
    run_frame(1, 0, -1);
    vecs++; if (got[0] !== 13'h1FFF || got[700] !== 13'h0001 || got_n !== 701 || !done_seen)
      begin errs++; $display("FAIL clear_next: got c0 %h final %h n %0d want 1fff 0001 701", got[0], got[700], got_n); end
  endtask

  task automatic test_reset_mid;
    fill(2);
    run_frame(1, 0, 5);
    #2; rst = 1'b0; #1;
    vecs++; if ({b0.out_valid, b0.in_ready, b0.out_last} !== 3'b0 || b0.out_coef !== 13'h0 || b0.out_idx !== 10'd0)
      begin errs++; $display("FAIL async_rst: got vld %b rdy %b coef %h idx %0d want 0 0 0 0", b0.out_valid, b0.in_ready, b0.out_coef, b0.out_idx); end
    #2; rst = 1'b1;
    @(posedge clk); #1;
    fill(1);
    run_frame(1, 0, -1);
    vecs++; if (got[0] !== 13'h0001 || got[1] !== 13'h0002 || got[700] !== 13'h1FFD || got_n !== 701)
      begin errs++; $display("FAIL rst_next: got %h %h final %h n %0d want 0001 0002 1ffd 701", got[0], got[1], got[700], got_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_allones();
    test_backpressure();
    test_small();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
